jk_reg_bank: RTL and testbench

- WIDTH-channel bank of mode-selectable flip-flops; each channel is an independent JK-class storage bit.
- A runtime mode selects JK, D, T or SR next-state logic for all channels at once.
- Adds what the single-bit JK cell lacks: clock enable, synchronous clear, per-bit change pulses, an illegal-SR sticky flag and a saturating activity counter.
- Sits wherever the design needs a bank of control flops with selectable update semantics, for example status/flag registers or counter stages.

---
 rtl/jk_reg_bank.sv | 129 ++++++++++++
 tb/tb_jk_reg_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// ----------------------------------------------------------------------------
// jk_reg_bank
//
// Purpose:
//   A bank of WIDTH independent storage bits whose update rule is chosen at
//   run time for all bits at once: JK, D, T or SR. Around the bare flops it
//   adds a clock enable, a synchronous clear, per-bit change pulses, a sticky
//   flag for illegal SR requests and a saturating count of edges on which
//   the stored state changed.
//
// Parameters:
//   WIDTH   - number of channels
//   RST_VAL - Q value loaded on async reset and on sclr
//   CNT_W   - width of the activity counter
//
// Ports:
//   Clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-low reset
//   en      in   1      clock enable for Q updates
//   sclr    in   1      synchronous clear, beats en and mode
//   mode    in   2      00 JK, 01 D, 10 T, 11 SR
//   J       in   WIDTH  J / D / T / S input per channel
//   K       in   WIDTH  K / R input per channel (unused in D and T)
//   Q       out  WIDTH  stored state
//   Qn      out  WIDTH  combinational complement of Q
//   chg     out  WIDTH  one-cycle pulse for each bit that changed last edge
//   sr_err  out  1      sticky flag, set by an enabled S=R=1 request
//   act_cnt out  CNT_W  saturating count of edges on which Q changed
// ----------------------------------------------------------------------------
module jk_reg_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sclr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] chg,
    output logic             sr_err,
    output logic [CNT_W-1:0] act_cnt
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mode_t            cur_mode;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_diff;
    logic [WIDTH-1:0] sr_illegal;
    logic             any_change;
    logic             any_illegal;
    logic             cnt_at_max;

    assign cur_mode = mode_t'(mode);

    // Candidate next state for every bit under the selected rule. This is
    // only committed on an enabled, non-cleared edge; the sequential block
    // decides whether to use it.
    always_comb begin
        q_next     = Q;
        sr_illegal = '0;
        case (cur_mode)
            MODE_JK: q_next = (J & ~Q) | (~K & Q);
            MODE_D:  q_next = J;
            MODE_T:  q_next = Q ^ J;
            MODE_SR: begin
                // Set on S&~R, clear on ~S&R, otherwise hold. S=R=1 falls
                // into the hold term, so an illegal bit keeps its value
                // while its neighbours still update.
                q_next     = (J & ~K) | (Q & (J | ~K));
                sr_illegal = J & K;
            end
            default: q_next = Q;
        endcase
    end

    // Change detection and counter saturation, shared by the register block.
    always_comb begin
        q_diff      = q_next ^ Q;
        any_change  = |q_diff;
        any_illegal = |sr_illegal;
        cnt_at_max  = (act_cnt == CNT_MAX);
    end

    // All state lives here. Priority is reset, then sclr, then en, then
    // hold. chg is a registered copy of the bits that flip on an enabled
    // edge, so it is naturally a one-cycle pulse.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            Q       <= RST_VAL;
            chg     <= '0;
            sr_err  <= 1'b0;
            act_cnt <= '0;
        end else if (sclr) begin
            Q       <= RST_VAL;
            chg     <= '0;
            sr_err  <= 1'b0;
            act_cnt <= '0;
        end else if (en) begin
            Q   <= q_next;
            chg <= q_diff;
            if (any_illegal) begin
                sr_err <= 1'b1;
            end
            if (any_change && !cnt_at_max) begin
                act_cnt <= act_cnt + 1'b1;
            end
        end else begin
            chg <= '0;
        end
    end

    // Complement output is purely combinational so it tracks Q through
    // reset as well.
    assign Qn = ~Q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// ----------------------------------------------------------------------------
// tb_jk_reg_bank
//
// Purpose:
//   Directed testbench for jk_reg_bank. Two instances share the stimulus:
//   the default 8-bit-counter bank and a CNT_W=2 bank used to exercise
//   counter saturation. Each scenario task drives vectors and compares the
//   outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_jk_reg_bank;

    logic       Clk;
    logic       rst;
    logic       en;
    logic       sclr;
    logic [1:0] mode;
    logic [7:0] J;
    logic [7:0] K;

    logic [7:0] Q;
    logic [7:0] Qn;
    logic [7:0] chg;
    logic       sr_err;
    logic [7:0] act_cnt;

    logic [7:0] q2;
    logic [7:0] qn2;
    logic [7:0] chg2;
    logic       sr_err2;
    logic [1:0] act_cnt2;

    int checks;
    int failures;

    jk_reg_bank #(.WIDTH(8), .CNT_W(8)) dut (
        .Clk(Clk), .rst(rst), .en(en), .sclr(sclr), .mode(mode),
        .J(J), .K(K), .Q(Q), .Qn(Qn), .chg(chg), .sr_err(sr_err),
        .act_cnt(act_cnt)
    );

    jk_reg_bank #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .Clk(Clk), .rst(rst), .en(en), .sclr(sclr), .mode(mode),
        .J(J), .K(K), .Q(q2), .Qn(qn2), .chg(chg2), .sr_err(sr_err2),
        .act_cnt(act_cnt2)
    );

    // 10 ns clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        // Load A5 via D mode, then pull reset low between edges.
        rst = 1'b1; sclr = 1'b0; en = 1'b1; mode = 2'b01; J = 8'hA5; K = 8'h00;
        step();
        checks++;
        if (Q !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL reset_preload Q got=%h exp=%h", Q, 8'hA5);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (Q !== 8'h00 || Qn !== 8'hFF || chg !== 8'h00 || act_cnt !== 8'd0 || sr_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset Q=%h Qn=%h chg=%h cnt=%0d err=%b exp Q=00 Qn=ff chg=00 cnt=0 err=0",
                     Q, Qn, chg, act_cnt, sr_err);
        end
        // An edge while reset is still low must not load J.
        step();
        checks++;
        if (Q !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_held_edge Q got=%h exp=%h", Q, 8'h00);
        end
        rst = 1'b1;
        step();
        checks++;
        if (Q !== 8'hA5 || act_cnt !== 8'd1) begin
            failures++;
            $display("[TB] FAIL reset_release Q=%h cnt=%0d exp Q=a5 cnt=1", Q, act_cnt);
        end
        // Synchronous clear with en low.
        en = 1'b0; sclr = 1'b1;
        step();
        checks++;
        if (Q !== 8'h00 || chg !== 8'h00 || act_cnt !== 8'd0 || sr_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sclr_clear Q=%h chg=%h cnt=%0d err=%b exp Q=00 chg=00 cnt=0 err=0",
                     Q, chg, act_cnt, sr_err);
        end
        sclr = 1'b0;
    endtask

    task automatic test_jk_walk();
        logic [7:0] jv [4] = '{8'hFF, 8'hFF, 8'h0F, 8'h00};
        logic [7:0] kv [4] = '{8'h00, 8'hFF, 8'hF0, 8'h00};
        logic [7:0] qe [4] = '{8'hFF, 8'h00, 8'h0F, 8'h0F};
        logic [7:0] ce [4] = '{8'hFF, 8'hFF, 8'h0F, 8'h00};
        en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            J = jv[i]; K = kv[i];
            step();
            checks++;
            if (Q !== qe[i] || chg !== ce[i] || Qn !== ~qe[i]) begin
                failures++;
                $display("[TB] FAIL jk_step%0d Q=%h chg=%h Qn=%h exp Q=%h chg=%h", i, Q, chg, Qn, qe[i], ce[i]);
            end
        end
        checks++;
        if (act_cnt !== 8'd3) begin
            failures++;
            $display("[TB] FAIL jk_act_cnt got=%0d exp=3", act_cnt);
        end
    endtask

    task automatic test_mode_mix();
        en = 1'b1; mode = 2'b01; J = 8'h3C; K = 8'h00;
        step();
        checks++;
        if (Q !== 8'h3C || chg !== 8'h33 || act_cnt !== 8'd4) begin
            failures++;
            $display("[TB] FAIL mix_d Q=%h chg=%h cnt=%0d exp Q=3c chg=33 cnt=4", Q, chg, act_cnt);
        end
        mode = 2'b10; J = 8'hFF;
        step();
        checks++;
        if (Q !== 8'hC3 || chg !== 8'hFF || act_cnt !== 8'd5) begin
            failures++;
            $display("[TB] FAIL mix_t Q=%h chg=%h cnt=%0d exp Q=c3 chg=ff cnt=5", Q, chg, act_cnt);
        end
        en = 1'b0;
        step();
        checks++;
        if (Q !== 8'hC3 || chg !== 8'h00 || act_cnt !== 8'd5) begin
            failures++;
            $display("[TB] FAIL mix_hold Q=%h chg=%h cnt=%0d exp Q=c3 chg=00 cnt=5", Q, chg, act_cnt);
        end
    endtask

    task automatic test_sr_illegal();
        sclr = 1'b1; en = 1'b0;
        step();
        sclr = 1'b0; en = 1'b1; mode = 2'b11; J = 8'h81; K = 8'h01;
        step();
        checks++;
        if (Q !== 8'h80 || sr_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sr_illegal Q=%h err=%b exp Q=80 err=1", Q, sr_err);
        end
        J = 8'h01; K = 8'h80;
        step();
        checks++;
        if (Q !== 8'h01 || sr_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sr_legal_sticky Q=%h err=%b exp Q=01 err=1", Q, sr_err);
        end
        mode = 2'b01; J = 8'h55;
        step();
        checks++;
        if (Q !== 8'h55 || sr_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sr_d_sticky Q=%h err=%b exp Q=55 err=1", Q, sr_err);
        end
        sclr = 1'b1;
        step();
        checks++;
        if (sr_err !== 1'b0 || Q !== 8'h00) begin
            failures++;
            $display("[TB] FAIL sr_sclr err=%b Q=%h exp err=0 Q=00", sr_err, Q);
        end
        // Illegal request with en low must not set the flag.
        sclr = 1'b0; en = 1'b0; mode = 2'b11; J = 8'hFF; K = 8'hFF;
        step();
        checks++;
        if (sr_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sr_disabled err got=%b exp=0", sr_err);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat;
        sclr = 1'b1; en = 1'b0;
        step();
        sclr = 1'b0; en = 1'b1; mode = 2'b10; J = 8'h01; K = 8'h00;
        for (int n = 1; n <= 6; n++) begin
            step();
            exp_sat = (n >= 3) ? 2'd3 : 2'(n);
            checks++;
            if (act_cnt2 !== exp_sat || chg2 !== 8'h01 || q2 !== {7'b0, n[0]} || act_cnt !== 8'(n)) begin
                failures++;
                $display("[TB] FAIL sat_edge%0d cnt2=%0d chg2=%h q2=%h cnt8=%0d exp cnt2=%0d chg2=01 q2=%h cnt8=%0d",
                         n, act_cnt2, chg2, q2, act_cnt, exp_sat, {7'b0, n[0]}, n);
            end
        end
    endtask

    task automatic test_priority();
        sclr = 1'b0; en = 1'b1; mode = 2'b01; J = 8'h5A; K = 8'h00;
        step();
        checks++;
        if (Q !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL prio_preload Q got=%h exp=5a", Q);
        end
        sclr = 1'b1; mode = 2'b00; J = 8'hFF; K = 8'hFF;
        step();
        checks++;
        if (Q !== 8'h00 || act_cnt !== 8'd0 || chg !== 8'h00) begin
            failures++;
            $display("[TB] FAIL prio_sclr_jk Q=%h cnt=%0d chg=%h exp Q=00 cnt=0 chg=00", Q, act_cnt, chg);
        end
        mode = 2'b11;
        step();
        checks++;
        if (sr_err !== 1'b0 || Q !== 8'h00) begin
            failures++;
            $display("[TB] FAIL prio_sclr_sr err=%b Q=%h exp err=0 Q=00", sr_err, Q);
        end
        sclr = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; en = 1'b0; sclr = 1'b0; mode = 2'b00; J = 8'h00; K = 8'h00;
        #12;
        rst = 1'b1;
        #10;
        test_reset();
        test_jk_walk();
        test_mode_mix();
        test_sr_illegal();
        test_saturation();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
